// File: rtl/udp_vlg_pkg.sv
// Shared UDP transmit types: payload beat, datagram metadata, arbiter state.
package udp_vlg_pkg;

   typedef struct packed {
      logic [7:0] dat;
      logic       val;
      logic       sof;
      logic       eof;
      logic       err;
   } stream_t;

   typedef struct packed {
      logic [31:0] ip_dst;
      logic [15:0] port_src;
      logic [15:0] port_dst;
      logic [15:0] len;
   } udp_meta_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      XMIT,
      RELEASE
   } udp_arb_fsm_t;

   // Reason code reported when the watchdog kills a stalled datagram.
   localparam logic [1:0] UDP_ABORT_TIMEOUT = 2'd1;

endpackage

// File: rtl/udp.sv
// UDP transmit handshake bundle between a source and the IPv4 layer.
interface udp;
   import udp_vlg_pkg::*;

   stream_t   strm;
   udp_meta_t meta;
   logic      rdy;
   logic      req;
   logic      ack;
   logic      done;

   modport out_tx (output strm, meta, rdy, input req, ack, done);
   modport in_rx  (input strm, meta, rdy, output req, ack, done);

endinterface

// File: rtl/udp_vlg_rr_pick.sv
// Combinational round-robin priority encoder: first set request above ptr, wrapping modulo N.
module udp_vlg_rr_pick #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   // Scan from the farthest candidate back to ptr+1 so the nearest hit is written last.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(ptr) + k) % N);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/udp_vlg_tx_arb.sv
// N-channel UDP transmit arbiter: round-robin grant per datagram, combinational
// forwarding of handshake and payload, watchdog abort of stalled clients.
module udp_vlg_tx_arb
   import udp_vlg_pkg::*;
#(
   parameter  int N       = 4,
   parameter  int TIMEOUT = 65535,
   localparam int IW      = $clog2(N),
   localparam int WW      = $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  stream_t       in_strm [N],
   input  udp_meta_t     in_meta [N],
   input  logic [N-1:0]  in_rdy,
   output logic [N-1:0]  in_req,
   output logic [N-1:0]  in_ack,
   output logic [N-1:0]  in_done,
   output logic [N-1:0]  in_tout,
   udp.out_tx            out,
   output logic [IW-1:0] gnt_idx,
   output logic          busy
);

   udp_arb_fsm_t  state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] gnt_q, gnt_d;
   udp_meta_t     meta_q, meta_d;
   logic [WW-1:0] wdog_q, wdog_d;

   logic [IW-1:0] pick_idx;
   logic          pick_any;
   logic          expire;
   logic          rdy_o;
   stream_t       strm_o;

   udp_vlg_rr_pick #(.N(N)) u_pick (
      .req (in_rdy),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign busy    = (state_q == GRANT) || (state_q == XMIT);
   assign gnt_idx = gnt_q;
   // A completion landing on the expiry cycle takes precedence over the abort.
   assign expire  = busy && (wdog_q == WW'(TIMEOUT)) && !((state_q == XMIT) && out.done);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(N - 1);
         gnt_q   <= '0;
         meta_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         meta_q  <= meta_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      meta_d  = meta_q;
      wdog_d  = wdog_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_idx;
               meta_d  = in_meta[pick_idx];
               wdog_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            wdog_d = wdog_q + 1'b1;
            if (expire || !in_rdy[gnt_q]) begin
               state_d = RELEASE;
            end else if (out.ack) begin
               state_d = XMIT;
            end
         end
         XMIT: begin
            wdog_d = wdog_q + 1'b1;
            if (out.done || expire) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            ptr_d   = gnt_q;
            wdog_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdy_o   = 1'b0;
      strm_o  = '0;
      in_req  = '0;
      in_ack  = '0;
      in_done = '0;
      in_tout = '0;
      case (state_q)
         GRANT: begin
            rdy_o          = 1'b1;
            in_ack[gnt_q]  = out.ack;
            in_req[gnt_q]  = out.req;
            in_tout[gnt_q] = expire;
         end
         XMIT: begin
            rdy_o          = 1'b1;
            strm_o         = in_strm[gnt_q];
            in_req[gnt_q]  = out.req;
            in_done[gnt_q] = out.done;
            in_tout[gnt_q] = expire;
            // Poison the frame on abort so IPv4 drops it instead of sending a runt.
            if (expire) begin
               strm_o.val = 1'b1;
               strm_o.eof = 1'b1;
               strm_o.err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign out.rdy  = rdy_o;
   assign out.strm = strm_o;
   assign out.meta = meta_q;

endmodule

// File: tb/tb_udp_vlg_tx_arb.sv
// Scoreboard bench for udp_vlg_tx_arb: expected grants and payload beats are queued
// by the stimulus and consumed by a negedge monitor.
module tb_udp_vlg_tx_arb;
   import udp_vlg_pkg::*;

   localparam int N       = 4;
   localparam int TIMEOUT = 24;
   localparam int IW      = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   stream_t       in_strm [N];
   udp_meta_t     in_meta [N];
   logic [N-1:0]  in_rdy;
   logic [N-1:0]  in_req, in_ack, in_done, in_tout;
   logic [IW-1:0] gnt_idx;
   logic          busy;

   udp u_if ();

   udp_vlg_tx_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_strm (in_strm),
      .in_meta (in_meta),
      .in_rdy  (in_rdy),
      .in_req  (in_req),
      .in_ack  (in_ack),
      .in_done (in_done),
      .in_tout (in_tout),
      .out     (u_if),
      .gnt_idx (gnt_idx),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_gnt [$];
   stream_t exp_beat [$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic udp_meta_t mk_meta(input int i);
      udp_meta_t m;
      m.ip_dst   = 32'h0A00_0010 + 32'(i);
      m.port_src = 16'h1000 + 16'(i);
      m.port_dst = 16'h2000 + 16'(i);
      m.len      = 16'd20 + 16'(i);
      return m;
   endfunction

   function automatic stream_t mk_beat(input int b, input int n);
      stream_t s;
      s.dat = 8'hA0 + 8'(b);
      s.val = 1'b1;
      s.sof = (b == 0);
      s.eof = (b == n - 1);
      s.err = 1'b0;
      return s;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!u_if.rdy && n < 50) begin
         tick();
         n++;
      end
      chk("wait_rdy_bound", 128'(u_if.rdy), 128'(1'b1));
   endtask

   // IPv4-side handshake plus client payload for one datagram on channel ch.
   task automatic do_xfer(input int ch, input int nbeats, input logic [N-1:0] drop);
      stream_t g;
      wait_rdy();
      u_if.ack = 1'b1;
      #1;
      chk("ack_route", 128'(in_ack), 128'(oh(ch)));
      tick();
      u_if.ack = 1'b0;
      u_if.req = 1'b1;
      for (int b = 0; b < nbeats; b++) begin
         in_strm[ch] = mk_beat(b, nbeats);
         for (int j = 0; j < N; j++) begin
            if (j != ch) begin
               g.dat = 8'($urandom);
               g.val = 1'b1;
               g.sof = 1'b1;
               g.eof = 1'b1;
               g.err = 1'($urandom);
               in_strm[j] = g;
            end
         end
         exp_beat.push_back(mk_beat(b, nbeats));
         #1;
         if (b == 0) chk("req_route", 128'(in_req), 128'(oh(ch)));
         tick();
      end
      in_strm[ch] = '0;
      u_if.done = 1'b1;
      #1;
      chk("done_route", 128'(in_done), 128'(oh(ch)));
      chk("no_tout_on_done", 128'(in_tout), 128'(0));
      tick();
      u_if.done = 1'b0;
      u_if.req  = 1'b0;
      in_rdy    = in_rdy & ~drop;
   endtask

   // Monitor: grant and payload checking, inter-grant gap, non-granted routing.
   initial begin
      logic    prev_rdy = 1'b0;
      int      gap = 0;
      bit      seen = 1'b0;
      int      g;
      stream_t bt;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (u_if.rdy && !prev_rdy) begin
               if (exp_gnt.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL grant_unexpected: got gnt_idx %0d with no grant queued at %0t", gnt_idx, $time);
               end else begin
                  g = exp_gnt.pop_front();
                  chk("grant_idx", 128'(gnt_idx), 128'(g));
                  chk("grant_meta", 128'(u_if.meta), 128'(mk_meta(g)));
                  if (seen) chk("rdy_gap_ge2", 128'(gap >= 2), 128'(1'b1));
               end
               seen = 1'b1;
            end
            if (u_if.strm.val) begin
               if (exp_beat.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL beat_unexpected: got %0h with no beat queued at %0t", u_if.strm, $time);
               end else begin
                  bt = exp_beat.pop_front();
                  chk("strm_beat", 128'(u_if.strm), 128'(bt));
               end
            end
            if (busy) chk("route_nongranted", 128'((in_req | in_ack | in_done | in_tout) & ~oh(int'(gnt_idx))), 128'(0));
         end
         if (u_if.rdy) gap = 0;
         else gap++;
         prev_rdy = u_if.rdy;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

   initial begin
      stream_t ab;
      int      c;
      bit      found;

      rst       = 1'b1;
      in_rdy    = '0;
      u_if.req  = 1'b1;
      u_if.ack  = 1'b1;
      u_if.done = 1'b1;
      for (int i = 0; i < N; i++) begin
         in_meta[i] = mk_meta(i);
         in_strm[i] = '0;
      end
      in_strm[3] = mk_beat(0, 1);
      repeat (2) tick();

      // Reset state, with the IPv4-side handshake inputs held high.
      chk("rst_rdy", 128'(u_if.rdy), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_gnt_idx", 128'(gnt_idx), 128'(0));
      chk("rst_meta", 128'(u_if.meta), 128'(0));
      chk("rst_strm", 128'(u_if.strm), 128'(0));
      chk("rst_client_outs", 128'({in_req, in_ack, in_done, in_tout}), 128'(0));
      u_if.req  = 1'b0;
      u_if.ack  = 1'b0;
      u_if.done = 1'b0;
      rst       = 1'b0;
      repeat (2) tick();

      // All four requesting continuously: strict rotation from channel 0.
      in_rdy = '1;
      for (int k = 0; k < 8; k++) begin
         exp_gnt.push_back(k % N);
         do_xfer(k % N, 2, (k == 7) ? '1 : '0);
      end
      repeat (2) tick();

      // Single requester on channel 2: one-cycle grant latency.
      exp_gnt.push_back(2);
      in_rdy = 4'b0100;
      tick();
      chk("grant_latency_rdy", 128'(u_if.rdy), 128'(1'b1));
      chk("grant_busy", 128'(busy), 128'(1'b1));
      do_xfer(2, 3, 4'b0100);
      repeat (2) tick();

      // Channel 1 streams 20 bytes while the others toggle their payload.
      exp_gnt.push_back(1);
      in_rdy = 4'b0010;
      do_xfer(1, 20, 4'b0010);
      repeat (2) tick();

      // Channel 0 acks but never completes: watchdog abort.
      in_strm[0] = '0;
      exp_gnt.push_back(0);
      in_rdy = 4'b0001;
      wait_rdy();
      u_if.ack = 1'b1;
      tick();
      u_if.ack = 1'b0;
      ab.dat = 8'h00;
      ab.val = 1'b1;
      ab.sof = 1'b0;
      ab.eof = 1'b1;
      ab.err = 1'b1;
      exp_beat.push_back(ab);
      c = 1;
      found = 1'b0;
      while (!found && c <= 60) begin
         if (in_tout != '0) found = 1'b1;
         else begin
            tick();
            c++;
         end
      end
      chk("tout_seen", 128'(found), 128'(1'b1));
      chk("tout_cycle", 128'(c), 128'(TIMEOUT));
      chk("tout_onehot", 128'(in_tout), 128'(4'b0001));
      tick();
      chk("tout_single_pulse", 128'(in_tout), 128'(0));
      chk("tout_release_rdy", 128'(u_if.rdy), 128'(0));
      in_rdy = '0;
      tick();
      chk("tout_idle_busy", 128'(busy), 128'(0));
      repeat (2) tick();

      // Completion on the expiry cycle: done wins, no abort.
      in_strm[1] = '0;
      exp_gnt.push_back(1);
      in_rdy = 4'b0010;
      wait_rdy();
      u_if.ack = 1'b1;
      tick();
      u_if.ack = 1'b0;
      repeat (TIMEOUT - 1) tick();
      u_if.done = 1'b1;
      #1;
      chk("race_done", 128'(in_done), 128'(4'b0010));
      chk("race_no_tout", 128'(in_tout), 128'(0));
      chk("race_no_poison", 128'(u_if.strm), 128'(0));
      tick();
      u_if.done = 1'b0;
      in_rdy = '0;
      chk("race_release_busy", 128'(busy), 128'(0));
      repeat (2) tick();

      // Channel 2 cancels in GRANT; channel 3 is served next.
      exp_gnt.push_back(2);
      exp_gnt.push_back(3);
      in_rdy = 4'b1100;
      tick();
      chk("cancel_granted", 128'(gnt_idx), 128'(2));
      in_rdy = 4'b1000;
      tick();
      chk("cancel_release_rdy", 128'(u_if.rdy), 128'(0));
      chk("cancel_release_busy", 128'(busy), 128'(0));
      do_xfer(3, 1, 4'b1000);
      repeat (2) tick();

      // Move ptr to 1, then reset in the middle of a channel 2 datagram.
      exp_gnt.push_back(1);
      in_rdy = 4'b0010;
      do_xfer(1, 1, 4'b0010);
      tick();
      exp_gnt.push_back(2);
      in_rdy = 4'b0100;
      wait_rdy();
      u_if.ack = 1'b1;
      tick();
      u_if.ack = 1'b0;
      u_if.req = 1'b1;
      in_strm[2] = mk_beat(0, 4);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_rdy", 128'(u_if.rdy), 128'(0));
      chk("arst_strm", 128'(u_if.strm), 128'(0));
      chk("arst_busy", 128'(busy), 128'(0));
      chk("arst_gnt_idx", 128'(gnt_idx), 128'(0));
      chk("arst_meta", 128'(u_if.meta), 128'(0));
      chk("arst_req", 128'(in_req), 128'(0));
      tick();
      u_if.req   = 1'b0;
      in_strm[2] = '0;
      in_rdy     = 4'b0110;
      rst        = 1'b0;
      exp_gnt.push_back(1);
      do_xfer(1, 1, 4'b0110);
      repeat (3) tick();

      chk("grant_queue_drained", 128'(exp_gnt.size()), 128'(0));
      chk("beat_queue_drained", 128'(exp_beat.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_vlg_tx_arb.md
# udp_vlg_tx_arb

Parametrised N-channel UDP transmit arbiter. Sits between N independent UDP transmit clients (DHCP, DNS, user ports, …) and the single UDP transmit path toward IPv4. Grants one client per datagram by round-robin, forwards that client's metadata, handshake and payload, and releases on completion. A watchdog aborts a stalled client so the shared path cannot lock up.

## Interface

Parameters:
- N, 4: number of client channels; valid range 2..16.
- TIMEOUT, 65535: maximum cycles a grant may stay active without `out.done` before abort; valid range 1..2^20-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_strm  in  stream_t [N]  per-client payload stream.
- in_meta  in  udp_meta_t [N]  per-client datagram metadata; stable while `in_rdy[i]` is high.
- in_rdy  in  [N]  per-client transmit request.
- in_req  out  [N]  payload request, routed to the granted client only.
- in_ack  out  [N]  metadata acknowledge, routed to the granted client only.
- in_done  out  [N]  completion, routed to the granted client only.
- in_tout  out  [N]  one-cycle abort pulse to the granted client on watchdog expiry.
- out  udp.out_tx  interface  aggregated transmit path toward IPv4.
- gnt_idx  out  $clog2(N)  index of the current or last grant.
- busy  out  1  high in GRANT or XMIT.

## Operation

Four states:
- IDLE: `out.rdy` is 0.
  - If any `in_rdy` is high, pick the first requester searching upward from `ptr+1` modulo N (`ptr` is the last granted index).
  - Register the winner in `gnt_idx`, latch its `in_meta` into a meta register and go to GRANT.
  - If no `in_rdy` is high, stay in IDLE.
- GRANT:
  - `out.rdy` is 1 and `out.meta` is the latched meta.
  - Route `out.ack` to `in_ack[gnt_idx]` and `out.req` to `in_req[gnt_idx]`.
  - On `out.ack` go to XMIT.
  - If `in_rdy[gnt_idx]` falls before ack (client cancel), go to RELEASE.
- XMIT:
  - `out.rdy` stays 1.
  - `out.strm` is a combinational mux of `in_strm[gnt_idx]`; `out.req` is still routed to the granted client.
  - On `out.done`, pulse `in_done[gnt_idx]` in the same cycle and go to RELEASE.
- RELEASE: one cycle.
  - `out.rdy` is 0 and `out.strm` is forced to 0.
  - Set `ptr <= gnt_idx` and return to IDLE.
  - This guarantees a minimum one-cycle `rdy` gap between datagrams.

Routing rules:
- Non-granted channels always see `in_req`, `in_ack`, `in_done` and `in_tout` at 0, and their `in_strm` is ignored.
- In IDLE and RELEASE, `out.strm` is forced to 0 (all fields, including `val`, `sof`, `eof`, `err`).

Watchdog:
- Counter width is $clog2(TIMEOUT+1). It clears on entry to GRANT and increments every cycle in GRANT/XMIT.
- When it equals TIMEOUT and `out.done` is not present in that cycle:
  - pulse `in_tout[gnt_idx]`;
  - if in XMIT, drive `out.strm.val=1`, `eof=1`, `err=1` for that one cycle so IPv4 discards the frame;
  - go to RELEASE.
- Simultaneous `out.done` and expiry: done wins, no timeout pulse.

Fairness and requester edge cases:
- A client that re-asserts `in_rdy` immediately after release is served only after all other pending requesters have been served once.
- `in_rdy` of the granted client during RELEASE is ignored.
- A single requester is re-granted after the one-cycle RELEASE gap.

## Timing

- Reset (async, on `rst` high): state IDLE, `ptr=N-1` (so the first search starts at channel 0), `gnt_idx=0`, `busy=0`, watchdog 0. All outputs 0: `out.rdy`, `out.strm`, `out.meta`, `in_req`, `in_ack`, `in_done`, `in_tout`.
- `rst` mid-datagram: the frame is truncated without an err marker; IPv4 is reset by the same `rst`.
- Grant latency: `in_rdy` high in cycle t gives `out.rdy` high in cycle t+1 with `out.meta` valid.
- Ack, req and done are forwarded combinationally (zero latency). Payload is forwarded combinationally (zero latency).
- Minimum `out.rdy` low time between consecutive grants: 2 cycles (RELEASE plus IDLE).
- `gnt_idx` changes only on the IDLE→GRANT transition.

## Structure

- Add the abort reason constant and the state enum `udp_arb_fsm_t` (IDLE, GRANT, XMIT, RELEASE) to `udp_vlg_pkg`.
- `stream_t` and `udp_meta_t` are reused from the existing packages unchanged.
- One natural sub-module: `udp_vlg_rr_pick`, a combinational N-wide round-robin priority encoder with inputs `req[N]` and `ptr` and outputs `idx` and `any`. Reusable by future RX demux or TCP arbitration.

## Test plan

- N=4: only `in_rdy[2]` is raised at t0 → `out.rdy` at t0+1 with `out.meta`=`in_meta[2]`; `gnt_idx`=2; only `in_ack[2]` follows `out.ack`.
- `in_rdy` held high on all four channels for 8 datagrams → grant order 0,1,2,3,0,1,2,3, with `out.rdy` low for at least 2 cycles between grants.
- Channel 1 streams a 20-byte payload after `out.req`, while channel 3 toggles its `in_strm` → `out.strm` matches channel 1 exactly, and `in_done[1]` pulses in the same cycle as `out.done`.
- TIMEOUT=10: granted client never finishes → after 10 cycles, `in_tout` pulses once, `out.strm` shows one cycle with `val`/`eof`/`err`=1, and the arbiter returns to IDLE.
- `out.done` and watchdog expiry fall in the same cycle → `in_done` pulses and `in_tout` stays 0. Separately, a client drops `in_rdy` in GRANT → RELEASE and the next requester is served.
- `rst` asserted mid-XMIT → all outputs are 0 asynchronously; after release, the first grant goes to the lowest requesting index.
